// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler draining four input FIFOs into four output FIFOs.
// A word's top two bits select its output FIFO; pops halt while any output is near full.
module fifo_rr_arbiter #(
  parameter int DATA_W = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [3:0]            in_empty_i,
  input  logic [4*DATA_W-1:0]   in_data_i,
  output logic [3:0]            in_pop_o,
  input  logic [3:0]            out_almost_full_i,
  input  logic [3:0]            out_full_i,
  output logic [3:0]            out_push_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [1:0]            grant_id_o,
  output logic                  pause_o,
  output logic                  idle_o,
  output logic                  overflow_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              state_q;
  logic [1:0]          grant_q;
  logic [1:0]          sel1_q;
  logic                v1_q;
  logic [3:0]          out_push_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                err_q;

  logic [3:0]          elig_s;
  logic                stall_s;
  logic                any_s;
  logic                pop_s;
  logic                busy_s;
  logic [1:0]          pick_s;
  logic [3:0]          in_pop_s;
  logic [DATA_W-1:0]   word_s;

  // Later offsets are overwritten by earlier ones, so the nearest requester after 'last' wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = last;
    for (int o = 4; o >= 1; o--) begin
      idx = last + 2'(o);
      if (req[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Arbitration decision and selection of the word popped last cycle.
  always_comb begin
    elig_s   = ~in_empty_i;
    stall_s  = (|out_almost_full_i) | (|out_full_i);
    any_s    = |elig_s;
    pick_s   = rr_pick(grant_q, elig_s);
    busy_s   = v1_q | (|out_push_q);
    pop_s    = ~reset_i & ~stall_s & any_s & (state_q != ST_PAUSE);
    if (pop_s) begin
      in_pop_s = 4'b0001 << pick_s;
    end else begin
      in_pop_s = 4'b0000;
    end
    case (sel1_q)
      2'd0:    word_s = in_data_i[0*DATA_W +: DATA_W];
      2'd1:    word_s = in_data_i[1*DATA_W +: DATA_W];
      2'd2:    word_s = in_data_i[2*DATA_W +: DATA_W];
      2'd3:    word_s = in_data_i[3*DATA_W +: DATA_W];
      default: word_s = {DATA_W{1'b0}};
    endcase
  end

  // Two-stage pop/push pipeline and sticky overflow detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q    <= 2'd3;
      sel1_q     <= 2'd0;
      v1_q       <= 1'b0;
      out_push_q <= 4'b0000;
      out_data_q <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      if (pop_s) begin
        grant_q <= pick_s;
        sel1_q  <= pick_s;
        v1_q    <= 1'b1;
      end else begin
        v1_q    <= 1'b0;
      end
      if (v1_q) begin
        out_data_q <= word_s;
        out_push_q <= 4'b0001 << word_s[DATA_W-1 -: 2];
      end else begin
        out_push_q <= 4'b0000;
      end
      if (|(out_push_q & out_full_i)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Scheduler state: RUN may only drop to IDLE once the pipeline has drained.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stall_s)    state_q <= ST_PAUSE;
          else if (any_s) state_q <= ST_RUN;
          else            state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (stall_s)                 state_q <= ST_PAUSE;
          else if (!any_s && !busy_s)  state_q <= ST_IDLE;
          else                         state_q <= ST_RUN;
        end
        ST_PAUSE: begin
          if (!stall_s && any_s) state_q <= ST_RUN;
          else if (!stall_s)     state_q <= ST_IDLE;
          else                   state_q <= ST_PAUSE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_pop_o       = in_pop_s;
  assign out_push_o     = out_push_q;
  assign out_data_o     = out_data_q;
  assign grant_id_o     = grant_q;
  assign pause_o        = (state_q == ST_PAUSE);
  assign idle_o         = (state_q == ST_IDLE);
  assign overflow_err_o = err_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the scheduler.
module tb_fifo_rr_arbiter;
  localparam int DW = 6;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_empty;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_pop;
  logic [3:0]      af;
  logic [3:0]      full;
  logic [3:0]      out_push;
  logic [DW-1:0]   out_data;
  logic [1:0]      grant_id;
  logic            pause;
  logic            idle;
  logic            overflow_err;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset), .in_empty_i(in_empty), .in_data_i(in_data),
    .in_pop_o(in_pop), .out_almost_full_i(af), .out_full_i(full),
    .out_push_o(out_push), .out_data_o(out_data), .grant_id_o(grant_id),
    .pause_o(pause), .idle_o(idle), .overflow_err_o(overflow_err)
  );

  // input FIFO environment
  logic [DW-1:0] fmem [4][256];
  int            head [4];
  int            tail [4];
  logic [DW-1:0] rdr  [4];

  // reference model: words scheduled to appear on the output at a given cycle
  typedef struct { int due; logic [DW-1:0] w; } pend_t;
  pend_t         pend[$];
  int            cyc;
  int            m_grant;
  int            m_mode;
  logic [DW-1:0] m_odata;
  logic          m_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      in_empty[i] = (tail[i] == head[i]);
      in_data[i*DW +: DW] = rdr[i];
    end
  endtask

  task automatic add_word(input int f, input logic [DW-1:0] w);
    fmem[f][tail[f] % 256] = w;
    tail[f]++;
    refresh();
  endtask

  function automatic int rr_next(input int last, input logic [3:0] el);
    for (int o = 1; o <= 4; o++) begin
      if (el[(last + o) % 4]) return (last + o) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    pend.delete();
    m_grant = 3;
    m_mode  = M_IDLE;
    m_odata = '0;
    m_err   = 1'b0;
  endfunction

  // One clock: check at the falling edge, advance model/environment after the rising edge.
  task automatic step();
    logic [3:0] el;
    logic       st;
    int         k;
    logic [3:0] e_pop;
    logic [3:0] e_push;
    logic [3:0] dpop;
    bit         busy;
    @(negedge clk);
    el = ~in_empty;
    st = (|af) | (|full);
    k  = rr_next(m_grant, el);
    e_pop = 4'b0000;
    if (!reset && m_mode != M_PAUSE && !st && k >= 0) e_pop[k] = 1'b1;
    e_push = 4'b0000;
    busy = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) e_push = 4'b0001 << pend[i].w[DW-1 -: 2];
      if (pend[i].due >= cyc) busy = 1'b1;
    end
    check("in_pop",   32'(in_pop),       32'(e_pop));
    check("out_push", 32'(out_push),     32'(e_push));
    check("out_data", 32'(out_data),     32'(m_odata));
    check("grant_id", 32'(grant_id),     32'(m_grant));
    check("pause",    32'(pause),        32'(m_mode == M_PAUSE));
    check("idle",     32'(idle),         32'(m_mode == M_IDLE));
    check("ovf_err",  32'(overflow_err), 32'(m_err));
    dpop = in_pop;
    if (reset) begin
      model_reset();
    end else begin
      if (|(e_push & full)) m_err = 1'b1;
      if (e_pop != 4'b0000) begin
        pend.push_back('{due: cyc + 2, w: fmem[k][head[k] % 256]});
        m_grant = k;
      end
      case (m_mode)
        M_IDLE:  m_mode = st ? M_PAUSE : ((|el) ? M_RUN : M_IDLE);
        M_RUN:   m_mode = st ? M_PAUSE : ((!(|el) && !busy) ? M_IDLE : M_RUN);
        default: m_mode = (!st && (|el)) ? M_RUN : (!st ? M_IDLE : M_PAUSE);
      endcase
      foreach (pend[i]) begin
        if (pend[i].due == cyc + 1) m_odata = pend[i].w;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    for (int i = 0; i < 4; i++) begin
      if (dpop[i] && tail[i] != head[i]) begin
        rdr[i] = fmem[i][head[i] % 256];
        head[i]++;
      end
    end
    refresh();
  endtask

  initial begin
    reset = 1'b1;
    af = 4'b0000;
    full = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
      rdr[i]  = '0;
    end
    refresh();
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // single FIFO with two words
    add_word(0, 6'h05);
    add_word(0, 6'h15);
    repeat (7) step();
    check("t1_idle", 32'(idle), 32'd1);

    // one word in every FIFO, starting from grant 3
    reset = 1'b1;
    step();
    reset = 1'b0;
    add_word(0, 6'h31);
    add_word(1, 6'h02);
    add_word(2, 6'h23);
    add_word(3, 6'h14);
    repeat (8) step();
    check("t2_grant", 32'(grant_id), 32'd3);

    // FIFOs 1 and 3 alternate, FIFO 0 joins mid-stream
    for (int i = 0; i < 3; i++) begin
      add_word(1, 6'(8'h10 + i));
      add_word(3, 6'(8'h30 + i));
    end
    repeat (2) step();
    add_word(0, 6'h2a);
    repeat (10) step();

    // almost_full pause with words in flight
    for (int i = 0; i < 3; i++) begin
      for (int f = 0; f < 4; f++) add_word(f, 6'($urandom_range(0, 63)));
    end
    repeat (3) step();
    af = 4'b0100;
    repeat (2) step();
    check("t4_pause", 32'(pause), 32'd1);
    repeat (2) step();
    af = 4'b0000;
    repeat (14) step();

    // push into a full output FIFO
    add_word(2, 6'h19);
    step();
    full = 4'b0010;
    repeat (3) step();
    full = 4'b0000;
    repeat (4) step();
    check("t5_ovf", 32'(overflow_err), 32'd1);

    // reset right after a pop
    add_word(1, 6'h07);
    add_word(1, 6'h27);
    step();
    reset = 1'b1;
    step();
    check("t6_grant", 32'(grant_id), 32'd3);
    check("t6_push",  32'(out_push), 32'd0);
    check("t6_ovf",   32'(overflow_err), 32'd0);
    reset = 1'b0;
    repeat (6) step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        int f;
        f = $urandom_range(0, 3);
        if (tail[f] - head[f] < 8) add_word(f, 6'($urandom_range(0, 63)));
      end
      af    = ($urandom_range(0, 7) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      full  = ($urandom_range(0, 39) == 0) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    af = 4'b0000;
    full = 4'b0000;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
